// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Boot-time program loader placed in front of Single_Cycle_Top. Accepts
// instruction words over a valid/ready stream, writes them sequentially into
// instruction memory starting at word address 0, holds the core in reset while
// loading, and releases the core's active-low reset RST_HOLD cycles after the
// last word has been transferred.
//
// Ports
//   clk         single clock, all state updates on its rising edge
//   rst         asynchronous active-low reset
//   s_valid     stream word valid
//   s_ready     loader accepts a word this cycle (registered)
//   s_data      instruction word
//   s_last      final program word, qualified by s_valid
//   imem_we     instruction-memory write enable (one cycle per transfer)
//   imem_addr   word address of the write
//   imem_wdata  write data
//   core_rst    active-low reset to Single_Cycle_Top.rst
//   done        core released and running
//   err_ovf     sticky program-overflow flag
//   load_count  number of words written (ADDR_WIDTH+1 bits, full memory fits)
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RST_HOLD   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst,
    output logic                  done,
    output logic                  err_ovf,
    output logic [ADDR_WIDTH:0]   load_count
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = {ADDR_WIDTH{1'b1}};

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_d;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_d;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_cnt_d;

    logic                  s_ready_d;
    logic                  imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_d;
    logic [DATA_WIDTH-1:0] imem_wdata_d;
    logic                  run_d;
    logic                  err_ovf_d;
    logic [CNT_W-1:0]      load_count_d;

    // s_ready is only ever high in LOAD, so this alone qualifies a transfer
    logic xfer_c;
    assign xfer_c = s_valid && s_ready;

    // State, pointer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_LOAD;
            ptr        <= '0;
            hold_cnt   <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b0;
            done       <= 1'b0;
            err_ovf    <= 1'b0;
            load_count <= '0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            hold_cnt   <= hold_cnt_d;
            s_ready    <= s_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            core_rst   <= run_d;
            done       <= run_d;
            err_ovf    <= err_ovf_d;
            load_count <= load_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        ptr_d        = ptr;
        hold_cnt_d   = hold_cnt;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        err_ovf_d    = err_ovf;
        load_count_d = load_count;

        case (state)
            ST_LOAD: begin
                if (xfer_c) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr;
                    imem_wdata_d = s_data;
                    ptr_d        = ptr + ADDR_WIDTH'(1);
                    load_count_d = load_count + CNT_W'(1);
                    // s_last wins: a last word in the final slot is a full, legal program
                    if (s_last) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else if (ptr == PTR_LAST) begin
                        state_d   = ST_ERR;
                        err_ovf_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        s_ready_d = (state_d == ST_LOAD);
        run_d     = (state_d == ST_RUN);
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

    localparam int unsigned AW0 = 3;
    localparam int unsigned AW1 = 2;
    localparam int unsigned RH0 = 4;
    localparam int unsigned RH1 = 1;
    localparam int unsigned DW  = 32;

    localparam logic [31:0] I0 = 32'h0050_0293;
    localparam logic [31:0] I1 = 32'h0030_0313;
    localparam logic [31:0] I2 = 32'h0062_83B3;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_valid;
    logic        s_last;
    logic [31:0] s_data;

    logic           rdy0, we0, crst0, done0, ovf0;
    logic [AW0-1:0] addr0;
    logic [31:0]    wd0;
    logic [AW0:0]   cnt0;

    logic           rdy1, we1, crst1, done1, ovf1;
    logic [AW1-1:0] addr1;
    logic [31:0]    wd1;
    logic [AW1:0]   cnt1;

    imem_boot_loader #(.ADDR_WIDTH(AW0), .DATA_WIDTH(DW), .RST_HOLD(RH0)) u_dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy0), .s_data(s_data),
        .s_last(s_last), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
        .core_rst(crst0), .done(done0), .err_ovf(ovf0), .load_count(cnt0)
    );

    imem_boot_loader #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW), .RST_HOLD(RH1)) u_dut1 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(rdy1), .s_data(s_data),
        .s_last(s_last), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
        .core_rst(crst1), .done(done1), .err_ovf(ovf1), .load_count(cnt1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memories behind each loader
    logic [31:0] bmem [2][8];
    always @(posedge clk) begin
        if (we0) bmem[0][addr0] <= wd0;
        if (we1) bmem[1][addr1] <= wd1;
    end

    // Reference model: words accepted, whether the last word was seen,
    // cycles elapsed since it, and the expected memory image.
    int          m_cnt   [2];
    bit          m_last  [2];
    bit          m_ovf   [2];
    bit          m_arm   [2];
    bit          m_we    [2];
    int          m_since [2];
    int          m_addr  [2];
    logic [31:0] m_wd    [2];
    logic [31:0] exp_mem [2][8];
    bit          exp_vld [2][8];

    function automatic int depth_of(input int k);
        return (k == 0) ? (1 << AW0) : (1 << AW1);
    endfunction

    function automatic int hold_of(input int k);
        return (k == 0) ? int'(RH0) : int'(RH1);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cnt[k]   <= 0;
                m_last[k]  <= 1'b0;
                m_ovf[k]   <= 1'b0;
                m_arm[k]   <= 1'b0;
                m_we[k]    <= 1'b0;
                m_since[k] <= 0;
                m_addr[k]  <= 0;
                m_wd[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (m_we[k]) begin
                    exp_mem[k][m_addr[k]] <= m_wd[k];
                    exp_vld[k][m_addr[k]] <= 1'b1;
                end
                m_arm[k] <= 1'b1;
                if (m_last[k]) m_since[k] <= m_since[k] + 1;
                if (m_arm[k] && !m_last[k] && !m_ovf[k] && s_valid) begin
                    m_we[k]   <= 1'b1;
                    m_addr[k] <= m_cnt[k] % depth_of(k);
                    m_wd[k]   <= s_data;
                    m_cnt[k]  <= m_cnt[k] + 1;
                    if (s_last) begin
                        m_last[k]  <= 1'b1;
                        m_since[k] <= 0;
                    end else if (m_cnt[k] + 1 == depth_of(k)) begin
                        m_ovf[k] <= 1'b1;
                    end
                end else begin
                    m_we[k] <= 1'b0;
                end
            end
        end
    end

    task automatic cmp_dut(input int k, input logic rdy, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic crst, input logic dn, input logic ov,
                           input logic [31:0] cnt);
        bit e_rdy;
        bit e_run;
        e_rdy = m_arm[k] && !m_last[k] && !m_ovf[k];
        e_run = m_last[k] && (m_since[k] >= hold_of(k));
        check($sformatf("model d%0d s_ready", k), 64'(rdy), 64'(e_rdy));
        check($sformatf("model d%0d imem_we", k), 64'(we), 64'(m_we[k]));
        check($sformatf("model d%0d imem_addr", k), 64'(addr), 64'(m_addr[k]));
        check($sformatf("model d%0d imem_wdata", k), 64'(wd), 64'(m_wd[k]));
        check($sformatf("model d%0d core_rst", k), 64'(crst), 64'(e_run));
        check($sformatf("model d%0d done", k), 64'(dn), 64'(e_run));
        check($sformatf("model d%0d err_ovf", k), 64'(ov), 64'(m_ovf[k]));
        check($sformatf("model d%0d load_count", k), 64'(cnt), 64'(m_cnt[k]));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp_dut(0, rdy0, we0, 32'(addr0), wd0, crst0, done0, ovf0, 32'(cnt0));
            cmp_dut(1, rdy1, we1, 32'(addr1), wd1, crst1, done1, ovf1, 32'(cnt1));
        end
    end

    task automatic mem_check();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < depth_of(k); a++) begin
                if (exp_vld[k][a])
                    check($sformatf("mem d%0d[%0d]", k, a), 64'(bmem[k][a]), 64'(exp_mem[k][a]));
            end
        end
    endtask

    // Called at a falling edge; asserts reset off-edge and checks its immediate effect
    task automatic do_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        #2 rst = 1'b0;
        #1;
        check("async core_rst d0", 64'(crst0), 64'd0);
        check("async imem_we d0", 64'(we0), 64'd0);
        check("async s_ready d0", 64'(rdy0), 64'd0);
        check("async done d0", 64'(done0), 64'd0);
        check("async load_count d0", 64'(cnt0), 64'd0);
        check("async core_rst d1", 64'(crst1), 64'd0);
        check("async imem_we d1", 64'(we1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic        l;
        logic [31:0] d;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] cnt;
        logic        run0;
        logic        run1;
    } vec_t;

    vec_t          tbl [9];
    bit            gap_v [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic   [31:0] seen [$];

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        chk_on  = 1'b1;

        tbl[0] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'd0, 32'h0, 32'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, I0,    1'b1, 1'b1, 32'd0, I0,    32'd1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, I1,    1'b1, 1'b1, 32'd1, I1,    32'd2, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, I2,    1'b0, 1'b1, 32'd2, I2,    32'd3, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, I2,    32'd3, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, I2,    32'd3, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, I2,    32'd3, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd2, I2,    32'd3, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b1, BAD,   1'b0, 1'b0, 32'd2, I2,    32'd3, 1'b1, 1'b1};

        // Reset values
        @(negedge clk);
        check("reset s_ready", 64'(rdy0), 64'd0);
        check("reset imem_we", 64'(we0), 64'd0);
        check("reset imem_addr", 64'(addr0), 64'd0);
        check("reset imem_wdata", 64'(wd0), 64'd0);
        check("reset core_rst", 64'(crst0), 64'd0);
        check("reset done", 64'(done0), 64'd0);
        check("reset err_ovf", 64'(ovf0), 64'd0);
        check("reset load_count", 64'(cnt0), 64'd0);
        @(negedge clk);
        #2 rst = 1'b1;

        // Basic load, release timing and minimum hold on d1
        for (int i = 0; i < 9; i++) begin
            s_valid = tbl[i].v;
            s_last  = tbl[i].l;
            s_data  = tbl[i].d;
            @(negedge clk);
            check($sformatf("vec%0d s_ready", i), 64'(rdy0), 64'(tbl[i].rdy));
            check($sformatf("vec%0d imem_we", i), 64'(we0), 64'(tbl[i].we));
            check($sformatf("vec%0d imem_addr", i), 64'(addr0), 64'(tbl[i].addr));
            check($sformatf("vec%0d imem_wdata", i), 64'(wd0), 64'(tbl[i].wd));
            check($sformatf("vec%0d load_count", i), 64'(cnt0), 64'(tbl[i].cnt));
            check($sformatf("vec%0d core_rst", i), 64'(crst0), 64'(tbl[i].run0));
            check($sformatf("vec%0d done", i), 64'(done0), 64'(tbl[i].run0));
            check($sformatf("vec%0d d1 core_rst", i), 64'(crst1), 64'(tbl[i].run1));
        end

        // RUN ignores the stream
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("run imem_we", 64'(we0), 64'd0);
            check("run load_count", 64'(cnt0), 64'd3);
            check("run core_rst", 64'(crst0), 64'd1);
            check("run d1 imem_we", 64'(we1), 64'd0);
        end
        check("basic mem0", 64'(bmem[0][0]), 64'(I0));
        check("basic mem1", 64'(bmem[0][1]), 64'(I1));
        check("basic mem2", 64'(bmem[0][2]), 64'(I2));

        // Gapped stream
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            s_valid = gap_v[i];
            s_last  = (i == 5);
            s_data  = 32'hA000_0000 + 32'(i);
            @(negedge clk);
            if (we0) seen.push_back(32'(addr0));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (we0) seen.push_back(32'(addr0));
        end
        check("gap write pulses", 64'(seen.size()), 64'd3);
        for (int j = 0; j < seen.size(); j++)
            check($sformatf("gap write addr %0d", j), 64'(seen[j]), 64'(j));

        // Mid-load reset: the second word's write is cut off
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hB000_0000 + 32'(i);
            @(negedge clk);
        end
        check("midload pre we", 64'(we0), 64'd1);
        check("midload pre addr", 64'(addr0), 64'd1);
        do_reset();
        @(negedge clk);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 32'hC0DE_0001;
        @(negedge clk);
        check("midload reload we", 64'(we0), 64'd1);
        check("midload reload addr", 64'(addr0), 64'd0);
        check("midload reload count", 64'(cnt0), 64'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("midload mem0", 64'(bmem[0][0]), 64'h0000_0000_C0DE_0001);
        check("midload mem1 kept", 64'(bmem[0][1]), 64'h0000_0000_A000_0003);

        // Overflow on the 4-word instance
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_last  = 1'b0;
            s_data  = 32'hD000_0000 + 32'(i);
            @(negedge clk);
            if (i == 3) begin
                check("ovf flag", 64'(ovf1), 64'd1);
                check("ovf s_ready", 64'(rdy1), 64'd0);
                check("ovf count", 64'(cnt1), 64'd4);
                check("ovf last addr", 64'(addr1), 64'd3);
            end
            if (i == 4) begin
                check("ovf 5th count", 64'(cnt1), 64'd4);
                check("ovf 5th we", 64'(we1), 64'd0);
            end
        end
        s_valid = 1'b0;
        repeat (RH0 + 2) @(negedge clk);
        check("ovf core_rst", 64'(crst1), 64'd0);
        check("ovf done", 64'(done1), 64'd0);
        for (int j = 0; j < 4; j++)
            check($sformatf("ovf mem%0d", j), 64'(bmem[1][j]), 64'(32'hD000_0000 + 32'(j)));

        // Minimum hold with a single-word program
        do_reset();
        @(negedge clk);
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 32'h1234_5678;
        @(negedge clk);
        check("minhold we", 64'(we1), 64'd1);
        check("minhold addr", 64'(addr1), 64'd0);
        check("minhold core_rst E0", 64'(crst1), 64'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        check("minhold core_rst E0+1", 64'(crst1), 64'd1);
        check("minhold done E0+1", 64'(done1), 64'd1);
        check("minhold mem0", 64'(bmem[1][0]), 64'h0000_0000_1234_5678);
        check("minhold d0 still held", 64'(crst0), 64'd0);

        // Randomized streams against the model
        for (int it = 0; it < 40; it++) begin
            do_reset();
            for (int c = 0; c < 48; c++) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_last  = ($urandom_range(0, 9) == 0);
                s_data  = $urandom;
                @(negedge clk);
                if ($urandom_range(0, 199) == 0) do_reset();
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
            repeat (RH0 + 2) @(negedge clk);
            mem_check();
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
